// File: rtl/rsa_modexp_pkg.sv
// Shared definitions for the RSA modular exponentiation unit: FSM encoding,
// default operand width and the fixed legal-operand latency.
package rsa_modexp_pkg;

    localparam int unsigned DefaultWidth = 26;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StRun,
        StFinish
    } state_e;

    // Cycles from the accepting edge to done for a legal operand.
    function automatic int unsigned lat(input int unsigned w);
        return w * (w + 1) + 2;
    endfunction

endpackage

// File: rtl/rsa_modexp_unit_modmul_seq.sv
// Sequential modular multiplier: one load cycle, then WIDTH MSB-first shift-add
// steps with conditional reduction so the accumulator stays below n.
module modmul_seq
    import rsa_modexp_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             rdy,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, b_q, n_q;
    logic [WIDTH+1:0] acc_q, n_ext, t0, t1, t2;
    logic [CW-1:0]    cnt_q;

    // 2*acc + a < 3n, so two subtractions always bring the value back below n.
    always_comb begin
        n_ext = {2'b00, n_q};
        t0    = {acc_q[WIDTH:0], 1'b0} + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
        t1    = (t0 >= n_ext) ? t0 - n_ext : t0;
        t2    = (t1 >= n_ext) ? t1 - n_ext : t1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (go) begin
            a_q   <= a;
            b_q   <= b;
            n_q   <= n;
            acc_q <= '0;
            cnt_q <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q <= t2;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign rdy = (cnt_q == '0);
    assign p   = acc_q[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_unit.sv
// Constant-time right-to-left square-and-multiply modular exponentiation,
// using two sequential modular multipliers running in lock-step.
module rsa_modexp_unit
    import rsa_modexp_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e           state;
    logic [WIDTH-1:0] r_q, b_q, exp_q, n_q;
    logic [WIDTH-1:0] r_cur, b_cur, p_mul, p_sqr;
    logic [CW-1:0]    bit_cnt;
    logic             go, mul_rdy, sqr_rdy, commit, last_bit, illegal;

    // b_q holds the captured msg while in CHECK.
    assign illegal  = (n_q < WIDTH'(2)) || (b_q >= n_q);
    assign commit   = (state == StRun) && mul_rdy && sqr_rdy;
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));
    assign go       = ((state == StCheck) && !illegal) || (commit && !last_bit);

    // The commit cycle doubles as the load cycle of the next bit's multiplies.
    always_comb begin
        r_cur = r_q;
        b_cur = b_q;
        if (commit) begin
            if (exp_q[0]) begin
                r_cur = p_mul;
            end
            b_cur = p_sqr;
        end
    end

    modmul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .a     (r_cur),
        .b     (b_cur),
        .n     (n_q),
        .rdy   (mul_rdy),
        .p     (p_mul)
    );

    modmul_seq #(.WIDTH(WIDTH)) u_sqr (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .a     (b_cur),
        .b     (b_cur),
        .n     (n_q),
        .rdy   (sqr_rdy),
        .p     (p_sqr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
            r_q     <= '0;
            b_q     <= '0;
            exp_q   <= '0;
            n_q     <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        state   <= StCheck;
                        busy    <= 1'b1;
                        r_q     <= WIDTH'(1);
                        b_q     <= msg;
                        n_q     <= n;
                        exp_q   <= mode ? d : e;
                        bit_cnt <= '0;
                    end
                end
                StCheck: begin
                    if (illegal) begin
                        state  <= StFinish;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                        result <= '0;
                    end else begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (commit) begin
                        r_q   <= r_cur;
                        b_q   <= b_cur;
                        exp_q <= exp_q >> 1;
                        if (last_bit) begin
                            state  <= StFinish;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            err    <= 1'b0;
                            result <= r_cur;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                StFinish: begin
                    state <= StIdle;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed self-checking bench for rsa_modexp_unit at the default width.
module tb_rsa_modexp_unit;

    localparam int W = 26;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [W-1:0] msg, e, d, n;
    logic         busy, done, err;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    rsa_modexp_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .msg    (msg),
        .e      (e),
        .d      (d),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one operation and waits (bounded) for done; cyc counts from the
    // start cycle as 0. Inputs are scrambled after acceptance.
    task automatic run_op(input logic m, input logic [W-1:0] mg, input logic [W-1:0] ev,
                          input logic [W-1:0] dv, input logic [W-1:0] nv,
                          output logic [W-1:0] res, output logic er, output int cyc);
        @(posedge clk);
        @(negedge clk);
        mode  = m;
        msg   = mg;
        e     = ev;
        d     = dv;
        n     = nv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~m;
        msg   = ~mg;
        e     = ~ev;
        d     = ~dv;
        n     = ~nv;
        cyc   = 1;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        res = done ? result : 'x;
        er  = done ? err : 1'bx;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        msg   = '0;
        e     = '0;
        d     = '0;
        n     = '0;
        #23;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt();
        logic [W-1:0] res;
        logic         er;
        int           cyc;
        run_op(1'b0, 26'd2, 26'd5, 26'd9, 26'd35, res, er, cyc);
        checks++;
        if (res !== 26'd32) begin errors++; $display("FAIL enc_result: got %0d want 32", res); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL enc_err: got %b want 0", er); end
        checks++;
        if (cyc !== 704) begin errors++; $display("FAIL enc_latency: got %0d want 704", cyc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL enc_busy_at_done: got %b want 0", busy); end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL enc_done_pulse: got %b want 0", done); end
        checks++;
        if (result !== 26'd32) begin errors++; $display("FAIL enc_hold: got %0d want 32", result); end
    endtask

    task automatic test_decrypt_sweep();
        logic [W-1:0] res, ct;
        logic         er;
        int           cyc;
        run_op(1'b1, 26'd32, 26'd9, 26'd5, 26'd35, res, er, cyc);
        checks++;
        if (res !== 26'd2) begin errors++; $display("FAIL dec_result: got %0d want 2", res); end
        for (int i = 0; i < 26; i++) begin
            run_op(1'b0, W'(i), 26'd5, 26'd0, 26'd35, ct, er, cyc);
            run_op(1'b1, ct, 26'd0, 26'd5, 26'd35, res, er, cyc);
            checks++;
            if (res !== W'(i) || er !== 1'b0) begin
                errors++;
                $display("FAIL sweep_roundtrip msg=%0d: got %0d err=%b want %0d err=0",
                         i, res, er, i);
            end
        end
    endtask

    task automatic test_edge_exponents();
        logic [W-1:0] res;
        logic         er;
        int           cyc;
        run_op(1'b0, 26'd7, 26'd0, 26'd3, 26'd35, res, er, cyc);
        checks++;
        if (res !== 26'd1) begin errors++; $display("FAIL exp_zero: got %0d want 1", res); end
        run_op(1'b0, 26'd0, 26'd5, 26'd3, 26'd35, res, er, cyc);
        checks++;
        if (res !== 26'd0) begin errors++; $display("FAIL msg_zero: got %0d want 0", res); end
    endtask

    task automatic test_illegal();
        logic [W-1:0] res;
        logic         er;
        int           cyc;
        run_op(1'b0, 26'd35, 26'd5, 26'd5, 26'd35, res, er, cyc);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL ill_msg_err: got %b want 1", er); end
        checks++;
        if (res !== 26'd0) begin errors++; $display("FAIL ill_msg_result: got %0d want 0", res); end
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL ill_msg_latency: got %0d want 2", cyc); end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ill_err_clear: got %b want 0", err); end
        run_op(1'b0, 26'd0, 26'd5, 26'd5, 26'd1, res, er, cyc);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL ill_n1_err: got %b want 1", er); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res;
        logic         er;
        int           cyc;
        run_op(1'b0, 26'd40, 26'd5, 26'd5, 26'd35, res, er, cyc);
        // Still in the done cycle: this start must be ignored.
        mode  = 1'b0;
        msg   = 26'd2;
        e     = 26'd5;
        n     = 26'd35;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_finish_start: busy %b want 0", busy); end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: busy %b want 1", busy); end
        cyc = 1;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (!done || result !== 26'd32 || cyc !== 704) begin
            errors++;
            $display("FAIL b2b_result: got %0d at cycle %0d want 32 at 704", result, cyc);
        end
    endtask

    task automatic test_restart_ignored();
        int done_cyc = -1;
        @(posedge clk);
        @(negedge clk);
        mode  = 1'b0;
        msg   = 26'd2;
        e     = 26'd5;
        n     = 26'd35;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 710 && done_cyc < 0; cyc++) begin
            if (cyc == 100) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
                msg   = 26'd3;
                e     = 26'd7;
                n     = 26'd33;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) done_cyc = cyc;
            if (done_cyc < 0) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (done_cyc !== 704 || result !== 26'd32) begin
            errors++;
            $display("FAIL ign_restart: got %0d at cycle %0d want 32 at 704", result, done_cyc);
        end
    endtask

    task automatic test_abort_reset();
        logic [W-1:0] res;
        logic         er;
        int           cyc;
        bit           saw_done = 0;
        @(posedge clk);
        @(negedge clk);
        mode  = 1'b0;
        msg   = 26'd3;
        e     = 26'd7;
        n     = 26'd35;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL abort_result: got %0d want 0", result); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
        run_op(1'b0, 26'd2, 26'd5, 26'd0, 26'd35, res, er, cyc);
        checks++;
        if (res !== 26'd32 || cyc !== 704) begin
            errors++;
            $display("FAIL abort_next_op: got %0d at cycle %0d want 32 at 704", res, cyc);
        end
    endtask

    task automatic test_wide();
        logic [W-1:0] res;
        logic         er;
        int           cyc;
        run_op(1'b0, 26'd67108858, 26'd2, 26'd0, 26'd67108859, res, er, cyc);
        checks++;
        if (res !== 26'd1 || er !== 1'b0) begin
            errors++;
            $display("FAIL wide_square: got %0d err=%b want 1 err=0", res, er);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt_sweep();
        test_edge_exponents();
        test_illegal();
        test_back_to_back();
        test_restart_ignored();
        test_abort_reset();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_unit.md
RSA_MODEXP_UNIT -- requirements
Module: rsa_modexp_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 26, giving the operand width in bits (minimum 4).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 SHALL have port mode, input, 1 bit: 0 selects encrypt (exponent e), 1 selects decrypt (exponent d).
REQ-006 SHALL have port msg, input, WIDTH bits: base operand (plaintext or ciphertext).
REQ-007 SHALL have port e, input, WIDTH bits: public exponent.
REQ-008 SHALL have port d, input, WIDTH bits: private exponent.
REQ-009 SHALL have port n, input, WIDTH bits: modulus.
REQ-010 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1 bit: valid with done; flags an illegal operand.
REQ-013 SHALL have port result, output, WIDTH bits: msg^exp mod n, held stable until the next accepted start.

Function
REQ-014 SHALL implement states IDLE, CHECK, RUN, FINISH: IDLE->CHECK on start; CHECK->FINISH if illegal, else CHECK->RUN; RUN->FINISH after the last exponent bit; FINISH->IDLE unconditionally.
REQ-015 SHALL capture msg, n, mode and the selected exponent on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-016 SHALL treat an operand as illegal when n < 2 or msg >= n; on an illegal operand result = 0, err = 1, and done SHALL pulse exactly 2 cycles after the accepting edge.
REQ-017 SHALL use right-to-left square-and-multiply: r = 1 and b = msg initially; for each exponent bit, LSB first, compute r*b mod n and b*b mod n in parallel, and commit r only when the bit is 1.
REQ-018 SHALL process all WIDTH exponent bits regardless of value (constant-time), so legal-operand latency is fixed at WIDTH*(WIDTH+1)+2 cycles from the accepting edge to done (704 for WIDTH=26).
REQ-019 Each modular multiply SHALL take WIDTH+1 cycles: 1 load cycle, then WIDTH MSB-first shift-add steps acc = 2*acc + bit*a followed by at most two conditional subtractions of n, keeping acc < n after each step.
REQ-020 The accumulator SHALL be WIDTH+2 bits wide so that no intermediate value overflows for any n < 2^WIDTH.
REQ-021 An exponent of 0 SHALL give result = 1; msg = 0 with a nonzero exponent SHALL give result = 0.
REQ-022 A start asserted while busy SHALL be ignored with no effect on the operation in flight.
REQ-023 A start asserted in the FINISH cycle SHALL be ignored; the earliest accepted restart is the cycle after done.
REQ-024 done and err SHALL be registered outputs; err SHALL be 0 whenever done is 0.

Reset
REQ-025 When rst_n is low, the FSM SHALL go to IDLE immediately and busy, done, err and result SHALL all be 0.
REQ-026 A reset mid-operation SHALL abort the operation without producing a done pulse; the first start after reset release SHALL behave exactly as a fresh operation.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the default WIDTH (26), and a latency constant function LAT(W) = W*(W+1)+2.
REQ-028 The block SHALL contain one sub-module, modmul_seq (parametrised WIDTH; ports clk, rst_n, go, a, b, n, rdy, p), instantiated twice: one instance for multiply, one for square.

Verification
REQ-029 n=35, e=5, mode=0, msg=2 -> result=32, err=0, done exactly 704 cycles after start.
REQ-030 n=35, d=5, mode=1, msg=32 -> result=2; then sweep msg 0..25 encrypt then decrypt -> each decrypt output equals the original msg.
REQ-031 n=35, e=0, msg=7 -> result=1; and n=35, e=5, msg=0 -> result=0.
REQ-032 n=35, msg=35 -> err=1, result=0, done 2 cycles after start; n=1, msg=0 -> err=1.
REQ-033 start re-pulsed at cycle 100 with different operands -> ignored, original result=32 still delivered at cycle 704; rst_n low at cycle 300 -> busy=0, result=0, no done pulse, and the next operation is correct.
REQ-034 n=2^26-5, msg=n-1, e=2 -> result=1 (exercises the maximum-width accumulator).
